// File: rtl/timer_counter.sv
// timer_counter
// -----------------------------------------------------------------------------
// Counting stage of the APB timer. It takes the enable and prescaler settings
// from the timer control register. It produces a prescaled count-enable pulse
// and keeps a 64-bit free-running count. Software can read and write the count
// as two 32-bit data registers.
//
// Ports
//   clk       in   1   system clock
//   rst_n     in   1   asynchronous active-low reset
//   timer_en  in   1   counting enable
//   div_en    in   1   prescaler enable
//   div_val   in   4   prescaler exponent (0..8): one pulse per 2^div_val cycles
//   halt_req  in   1   debug halt request
//   addr      in  32   APB register byte address
//   wr_en     in   1   APB write strobe (one cycle per access)
//   wdata     in  32   APB write data
//   cnt_en    out  1   count-enable pulse; the count advances in this cycle
//   cnt       out 64   current count {tdr1, tdr0}
//   tdr0      out 32   count[31:0]
//   tdr1      out 32   count[63:32]
//   halt_ack  out  1   halt_req delayed by one cycle
// -----------------------------------------------------------------------------
module timer_counter #(
    parameter logic [31:0] TDR0_ADDR = 32'h004,
    parameter logic [31:0] TDR1_ADDR = 32'h008
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        timer_en,
    input  logic        div_en,
    input  logic [3:0]  div_val,
    input  logic        halt_req,
    input  logic [31:0] addr,
    input  logic        wr_en,
    input  logic [31:0] wdata,
    output logic        cnt_en,
    output logic [63:0] cnt,
    output logic [31:0] tdr0,
    output logic [31:0] tdr1,
    output logic        halt_ack
);

    logic [63:0] cnt_q, cnt_d;
    logic [7:0]  int_cnt_q, int_cnt_d;
    logic        halt_ack_q;
    logic        timer_en_dly_q;

    logic [8:0]  limit_full;
    logic        count_active;
    logic        prescale_hit;
    logic        wr_lo, wr_hi;
    logic        en_fall;

    // The prescaler limit is (1 << div_val) - 1.
    // A 9-bit intermediate keeps div_val = 8 (limit 255) exact.
    assign limit_full   = (9'd1 << div_val) - 9'd1;

    assign count_active = timer_en & ~halt_ack_q;

    // '>=' rather than '==' so that lowering div_val below the current
    // prescaler phase fires at once instead of waiting for an 8-bit wrap.
    assign prescale_hit = ~div_en | (int_cnt_q >= limit_full[7:0]);

    // Gate with rst_n so that no pulse leaks out while reset is held.
    // timer_en may still be high from the control register during reset.
    assign cnt_en  = rst_n & count_active & prescale_hit;

    assign wr_lo   = wr_en & (addr == TDR0_ADDR);
    assign wr_hi   = wr_en & (addr == TDR1_ADDR);
    assign en_fall = timer_en_dly_q & ~timer_en;

    // Prescaler phase.
    always_comb begin
        int_cnt_d = int_cnt_q;
        if (!timer_en || !div_en) begin
            int_cnt_d = 8'd0;
        end else if (!halt_ack_q) begin
            if (prescale_hit) begin
                int_cnt_d = 8'd0;
            end else begin
                int_cnt_d = int_cnt_q + 8'd1;
            end
        end
    end

    // Count update. A software write wins over everything else, and only the
    // written half changes. A halt freezes the count, including the clear on
    // disable. Otherwise a timer_en falling edge clears the count, or a pulse
    // increments it. The increment wraps silently.
    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo || wr_hi) begin
            if (wr_lo) begin
                cnt_d[31:0] = wdata;
            end
            if (wr_hi) begin
                cnt_d[63:32] = wdata;
            end
        end else if (!halt_ack_q) begin
            if (en_fall) begin
                cnt_d = 64'd0;
            end else if (cnt_en) begin
                cnt_d = cnt_q + 64'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= 64'd0;
            int_cnt_q      <= 8'd0;
            halt_ack_q     <= 1'b0;
            timer_en_dly_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            int_cnt_q      <= int_cnt_d;
            halt_ack_q     <= halt_req;
            timer_en_dly_q <= timer_en;
        end
    end

    assign cnt      = cnt_q;
    assign tdr0     = cnt_q[31:0];
    assign tdr1     = cnt_q[63:32];
    assign halt_ack = halt_ack_q;

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
Counting stage of the APB timer, directly downstream of the timer control register.
- Consumes timer_en, div_en and div_val from the control register.
- Generates a prescaled count-enable pulse and maintains the 64-bit timer count.
- The count is exposed as two 32-bit data registers, TDR0 (low) at 0x004 and TDR1 (high) at 0x008. Software can write either half.
- Outputs cnt_en and the full count to the compare/interrupt stage and to the APB read mux.

Parameters:
- TDR0_ADDR, 32'h004, byte address of the low count word.
- TDR1_ADDR, 32'h008, byte address of the high count word.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- timer_en  input  1  counting enable from the control register
- div_en  input  1  prescaler enable from the control register
- div_val  input  4  prescaler exponent, legal 0..8 (guaranteed by the control register)
- halt_req  input  1  debug halt request, freezes counting
- addr  input  32  APB register address
- wr_en  input  1  APB write strobe, one cycle per access
- wdata  input  32  APB write data
- cnt_en  output  1  one-cycle pulse, the counter advances this cycle
- cnt  output  64  current count {tdr1, tdr0}
- tdr0  output  32  count[31:0]
- tdr1  output  32  count[63:32]
- halt_ack  output  1  registered acknowledge of halt_req

Behaviour:
Reset values (rst_n low, async):
- cnt = 0, int_cnt = 0, cnt_en = 0, halt_ack = 0, timer_en_d = 0.

Halt:
- halt_ack <= halt_req each cycle, so acknowledge has a 1-cycle latency.
- While halt_ack = 1, int_cnt and cnt hold. cnt_en is forced to 0.
- Software writes are still accepted while halted.

Prescaler (internal 8-bit int_cnt; limit = (1 << div_val) - 1):
- Active when timer_en = 1 and halt_ack = 0.
- div_en = 0: cnt_en = 1 every active cycle; int_cnt is held at 0.
- div_en = 1:
  - cnt_en = 1 when int_cnt >= limit, and int_cnt is cleared to 0 in that cycle.
  - Otherwise int_cnt increments.
  - Using >= covers a div_val decrease mid-count.
  - div_val = 0 gives a pulse every cycle; div_val = 8 gives one pulse per 256 cycles.
- int_cnt is cleared whenever timer_en = 0 or div_en = 0.
- cnt_en is combinational from int_cnt and the inputs. It is asserted in the same cycle the counter register updates.

Counter:
- cnt increments by 1 on cnt_en.
- Wraps from 64'hFFFF_FFFF_FFFF_FFFF to 0 with no flag.

Software write:
- wr_en & addr == TDR0_ADDR: cnt[31:0] <= wdata.
- wr_en & addr == TDR1_ADDR: cnt[63:32] <= wdata.
- A write has priority over an increment in the same cycle. The unwritten half keeps its old value, with no increment and no carry.
- Writes to any other address are ignored.

Disable clear:
- timer_en_d is timer_en registered.
- On the falling edge of timer_en (timer_en_d = 1, timer_en = 0), cnt is cleared to 0 the next clock.
- A same-cycle TDR write has priority over this clear.

Enable edge:
- On a timer_en rise, the first pulse arrives:
  - in the same cycle if div_en = 0;
  - after 2^div_val cycles if div_en = 1.

Reset mid-operation:
- Everything returns to reset values immediately. No pulse is emitted in the reset cycle.

Test Plan:
- Reset, then timer_en = 1, div_en = 0 for 10 cycles -> cnt = 10, cnt_en high every cycle.
- div_en = 1, div_val = 3, timer_en = 1 for 32 cycles -> cnt_en pulses every 8th cycle, cnt = 4.
- Write TDR0 = 32'hFFFF_FFFF, TDR1 = 32'hFFFF_FFFF, then enable with div_en = 0 -> cnt = 0 after one increment, then 1.
- With timer_en = 1, div_en = 0, TDR0 write of 32'h100 in the same cycle as an increment -> tdr0 = 32'h100 (write wins), tdr1 unchanged.
- halt_req = 1 while counting -> halt_ack high the next cycle, cnt frozen. Release -> resumes from the same value, and int_cnt phase is preserved.
- Count to 5, drop timer_en -> cnt = 0 the next cycle. Change div_val from 8 to 1 mid-count with int_cnt = 50 -> immediate cnt_en pulse, then period 2. Assert rst_n low mid-count -> all outputs 0 asynchronously.
